uart_port: RTL and testbench

Parametrised UART transceiver with transmit and receive FIFOs. It replaces the fixed 8-bit, even-parity, 1-stop serial block with configurable frame format, FIFO depth and bit period. It adds sticky error reporting, a busy indicator and a reset-safe receive synchroniser. It sits between the CPU's memory-mapped I/O controller and the board's serial pins.

---
 rtl/uart_port.sv | 283 ++++++++++++++++++++++++++++
 tb/tb_uart_port.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_port.sv
// uart_port: UART transceiver with TX/RX FIFOs; UART_LOOPBACK_EN adds a loopback input that routes Tx into RX.
// Latency: Tx falls 2 cycles after send_flag; a received byte is visible 3 + CLKS_PER_BIT/2 cycles after its stop bit starts.
// Backpressure: sendable drops while the TX FIFO is full; with the RX FIFO full, valid frames are dropped and err_overrun is set.

module uart_port_fifo #(
  parameter int W  = 8,
  parameter int AW = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout,
  output logic         full,
  output logic         empty
);
  logic [AW:0]  wr_q, wr_d, rd_q, rd_d;
  logic [W-1:0] mem_q [2**AW];
  logic         do_push, do_pop;

  // The extra pointer bit tells a full buffer from an empty one.
  assign empty   = (wr_q == rd_q);
  assign full    = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign dout    = mem_q[rd_q[AW-1:0]];

  always_comb begin
    wr_d = do_push ? wr_q + (AW+1)'(1) : wr_q;
    rd_d = do_pop  ? rd_q + (AW+1)'(1) : rd_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      wr_q <= wr_d;
      rd_q <= rd_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_q[AW-1:0]] <= din;
  end
endmodule

module uart_port #(
  parameter int CLKS_PER_BIT = 9375,
  parameter int DATA_BITS    = 8,
  parameter int PARITY       = 1,
  parameter int STOP_BITS    = 1,
  parameter int FIFO_AW      = 4
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic                 send_flag,
  input  logic [DATA_BITS-1:0] send_data,
  input  logic                 recv_flag,
  output logic [DATA_BITS-1:0] recv_data,
  output logic                 sendable,
  output logic                 receivable,
  output logic                 tx_busy,
  output logic                 err_parity,
  output logic                 err_frame,
  output logic                 err_overrun,
  input  logic                 err_clear,
`ifdef UART_LOOPBACK_EN
  input  logic                 loopback,
`endif
  output logic                 Tx,
  input  logic                 Rx
);
  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam int IDX_W = $clog2(DATA_BITS);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] CNT_MID  = CNT_W'(CLKS_PER_BIT / 2);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_BITS - 1);
  localparam logic             PAR_ODD  = (PARITY == 2);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_START = 3'd1;
  localparam logic [2:0] S_DATA  = 3'd2;
  localparam logic [2:0] S_PAR   = 3'd3;
  localparam logic [2:0] S_STOP  = 3'd4;
  localparam logic [2:0] S_WAIT  = 3'd5;

  logic [2:0]           tx_st_q, tx_st_d;
  logic [CNT_W-1:0]     tx_cnt_q, tx_cnt_d;
  logic [IDX_W-1:0]     tx_idx_q, tx_idx_d;
  logic [DATA_BITS-1:0] tx_sh_q, tx_sh_d;
  logic                 tx_par_q, tx_par_d, tx_stop_q, tx_stop_d;
  logic                 tx_q, tx_d, sendable_q, sendable_d, busy_q, busy_d;
  logic                 tx_end, tx_load;
  logic                 txf_push, txf_pop, txf_full, txf_empty;
  logic [DATA_BITS-1:0] txf_dout;

  logic [2:0]           rx_st_q, rx_st_d;
  logic [CNT_W-1:0]     rx_cnt_q, rx_cnt_d;
  logic [IDX_W-1:0]     rx_idx_q, rx_idx_d;
  logic [DATA_BITS-1:0] rx_sh_q, rx_sh_d;
  logic                 rx_par_q, rx_par_d;
  logic                 rx_meta_q, rx_sync_q, rx_in;
  logic                 rx_mid, rx_end, new_par, new_frm, new_ovr;
  logic                 err_par_q, err_par_d, err_frm_q, err_frm_d, err_ovr_q, err_ovr_d;
  logic                 rxf_push, rxf_full, rxf_empty;
  logic [DATA_BITS-1:0] rxf_dout;

`ifdef UART_LOOPBACK_EN
  assign rx_in = loopback ? tx_q : Rx;
  assign Tx    = loopback ? 1'b1 : tx_q;
`else
  assign rx_in = Rx;
  assign Tx    = tx_q;
`endif

  assign txf_push    = send_flag && sendable_q;
  assign sendable    = sendable_q;
  assign tx_busy     = busy_q;
  assign receivable  = !rxf_empty;
  assign recv_data   = rxf_empty ? '0 : rxf_dout;
  assign err_parity  = err_par_q;
  assign err_frame   = err_frm_q;
  assign err_overrun = err_ovr_q;

  uart_port_fifo #(.W(DATA_BITS), .AW(FIFO_AW)) u_tx_fifo (
    .clk(CLK), .rst(RST), .push(txf_push), .pop(txf_pop), .din(send_data),
    .dout(txf_dout), .full(txf_full), .empty(txf_empty)
  );

  uart_port_fifo #(.W(DATA_BITS), .AW(FIFO_AW)) u_rx_fifo (
    .clk(CLK), .rst(RST), .push(rxf_push), .pop(recv_flag), .din(rx_sh_q),
    .dout(rxf_dout), .full(rxf_full), .empty(rxf_empty)
  );

  always_comb begin
    tx_st_d   = tx_st_q;
    tx_cnt_d  = tx_cnt_q;
    tx_idx_d  = tx_idx_q;
    tx_sh_d   = tx_sh_q;
    tx_par_d  = tx_par_q;
    tx_stop_d = tx_stop_q;
    tx_load   = 1'b0;
    tx_end    = (tx_cnt_q == CNT_LAST);
    if (tx_st_q != S_IDLE) tx_cnt_d = tx_end ? '0 : tx_cnt_q + CNT_W'(1);
    case (tx_st_q)
      S_IDLE:  tx_load = !txf_empty;
      S_START: if (tx_end) begin
        tx_st_d  = S_DATA;
        tx_idx_d = '0;
      end
      S_DATA: if (tx_end) begin
        tx_sh_d   = tx_sh_q >> 1;
        tx_idx_d  = tx_idx_q + IDX_W'(1);
        tx_stop_d = 1'b0;
        if (tx_idx_q == IDX_LAST) tx_st_d = (PARITY != 0) ? S_PAR : S_STOP;
      end
      S_PAR: if (tx_end) tx_st_d = S_STOP;
      S_STOP: if (tx_end) begin
        if (STOP_BITS == 2 && !tx_stop_q) tx_stop_d = 1'b1;
        else begin
          tx_st_d = S_IDLE;
          tx_load = !txf_empty;  // chain straight into the next frame
        end
      end
      default: tx_st_d = S_IDLE;
    endcase
    txf_pop = tx_load;
    if (tx_load) begin
      tx_st_d  = S_START;
      tx_cnt_d = '0;
      tx_sh_d  = txf_dout;
      tx_par_d = (^txf_dout) ^ PAR_ODD;
    end
    case (tx_st_q)
      S_START: tx_d = 1'b0;
      S_DATA:  tx_d = tx_sh_q[0];
      S_PAR:   tx_d = tx_par_q;
      default: tx_d = 1'b1;
    endcase
    sendable_d = !txf_full;
    busy_d     = (tx_st_q != S_IDLE) || !txf_empty;
  end

  always_comb begin
    rx_st_d  = rx_st_q;
    rx_cnt_d = rx_cnt_q;
    rx_idx_d = rx_idx_q;
    rx_sh_d  = rx_sh_q;
    rx_par_d = rx_par_q;
    rxf_push = 1'b0;
    new_par  = 1'b0;
    new_frm  = 1'b0;
    new_ovr  = 1'b0;
    rx_mid   = (rx_cnt_q == CNT_MID);
    rx_end   = (rx_cnt_q == CNT_LAST);
    if (rx_st_q != S_IDLE && rx_st_q != S_WAIT) rx_cnt_d = rx_end ? '0 : rx_cnt_q + CNT_W'(1);
    case (rx_st_q)
      // The detection cycle counts as bit-time 0, keeping samples centred.
      S_IDLE: if (!rx_sync_q) begin
        rx_st_d  = S_START;
        rx_cnt_d = CNT_W'(1);
      end
      S_START: begin
        if (rx_mid && rx_sync_q) rx_st_d = S_IDLE;
        else if (rx_end) begin
          rx_st_d  = S_DATA;
          rx_idx_d = '0;
        end
      end
      S_DATA: begin
        if (rx_mid) rx_sh_d = {rx_sync_q, rx_sh_q[DATA_BITS-1:1]};
        if (rx_end) begin
          rx_idx_d = rx_idx_q + IDX_W'(1);
          if (rx_idx_q == IDX_LAST) rx_st_d = (PARITY != 0) ? S_PAR : S_STOP;
        end
      end
      S_PAR: begin
        if (rx_mid) rx_par_d = rx_sync_q;
        if (rx_end) rx_st_d = S_STOP;
      end
      S_STOP: if (rx_mid) begin
        new_par = (PARITY != 0) && (rx_par_q != ((^rx_sh_q) ^ PAR_ODD));
        new_frm = !rx_sync_q;
        if (!new_par && !new_frm) begin
          rxf_push = 1'b1;
          new_ovr  = rxf_full && !recv_flag;
        end
        rx_st_d = new_frm ? S_WAIT : S_IDLE;
      end
      S_WAIT: if (rx_sync_q) rx_st_d = S_IDLE;
      default: rx_st_d = S_IDLE;
    endcase
    err_par_d = (err_par_q && !err_clear) || new_par;
    err_frm_d = (err_frm_q && !err_clear) || new_frm;
    err_ovr_d = (err_ovr_q && !err_clear) || new_ovr;
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      tx_st_q    <= S_IDLE;
      tx_cnt_q   <= '0;
      tx_idx_q   <= '0;
      tx_sh_q    <= '0;
      tx_par_q   <= 1'b0;
      tx_stop_q  <= 1'b0;
      tx_q       <= 1'b1;
      sendable_q <= 1'b1;
      busy_q     <= 1'b0;
      rx_st_q    <= S_IDLE;
      rx_cnt_q   <= '0;
      rx_idx_q   <= '0;
      rx_sh_q    <= '0;
      rx_par_q   <= 1'b0;
      rx_meta_q  <= 1'b1;
      rx_sync_q  <= 1'b1;
      err_par_q  <= 1'b0;
      err_frm_q  <= 1'b0;
      err_ovr_q  <= 1'b0;
    end else begin
      tx_st_q    <= tx_st_d;
      tx_cnt_q   <= tx_cnt_d;
      tx_idx_q   <= tx_idx_d;
      tx_sh_q    <= tx_sh_d;
      tx_par_q   <= tx_par_d;
      tx_stop_q  <= tx_stop_d;
      tx_q       <= tx_d;
      sendable_q <= sendable_d;
      busy_q     <= busy_d;
      rx_st_q    <= rx_st_d;
      rx_cnt_q   <= rx_cnt_d;
      rx_idx_q   <= rx_idx_d;
      rx_sh_q    <= rx_sh_d;
      rx_par_q   <= rx_par_d;
      rx_meta_q  <= rx_in;
      rx_sync_q  <= rx_meta_q;
      err_par_q  <= err_par_d;
      err_frm_q  <= err_frm_d;
      err_ovr_q  <= err_ovr_d;
    end
  end
endmodule

// File: tb/tb_uart_port.sv
// Directed bench for uart_port with a byte scoreboard for RX and a bit-level model for TX.
module tb_uart_port;
  localparam int C = 16;

  logic       clk = 1'b0, rst = 1'b1;
  logic       send_flag = 1'b0, recv_flag = 1'b0, err_clear = 1'b0, rx = 1'b1;
  logic [7:0] send_data = '0;
  logic [7:0] recv_data;
  logic       sendable, receivable, tx_busy, err_parity, err_frame, err_overrun, tx;
`ifdef UART_LOOPBACK_EN
  logic       loopback = 1'b0;
`endif

  int         n_cmp = 0, n_fail = 0;
  logic [7:0] rx_exp[$];
  logic       tx_exp[$];
  logic       par_exp = 1'b0, frm_exp = 1'b0, ovr_exp = 1'b0;

  always #5 clk = ~clk;

  uart_port #(.CLKS_PER_BIT(C), .DATA_BITS(8), .PARITY(1), .STOP_BITS(1), .FIFO_AW(2)) dut (
    .CLK(clk), .RST(rst), .send_flag(send_flag), .send_data(send_data),
    .recv_flag(recv_flag), .recv_data(recv_data), .sendable(sendable), .receivable(receivable),
    .tx_busy(tx_busy), .err_parity(err_parity), .err_frame(err_frame), .err_overrun(err_overrun),
    .err_clear(err_clear),
`ifdef UART_LOOPBACK_EN
    .loopback(loopback),
`endif
    .Tx(tx), .Rx(rx)
  );

  initial begin
    #2000000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_errs(input string tag);
    chk({tag, "_par"}, err_parity, par_exp);
    chk({tag, "_frm"}, err_frame, frm_exp);
    chk({tag, "_ovr"}, err_overrun, ovr_exp);
    chk({tag, "_recv"}, receivable, rx_exp.size() != 0);
  endtask

  task automatic rx_bit(input logic b);
    rx = b;
    repeat (C) @(posedge clk);
    #1;
  endtask

  task automatic rx_head(input logic [7:0] d, input logic flip);
    rx_bit(1'b0);
    for (int i = 0; i < 8; i++) rx_bit(d[i]);
    rx_bit((^d) ^ flip);
  endtask

  task automatic rx_frame(input logic [7:0] d, input logic flip, input logic stop);
    if (!flip && stop) begin
      if (rx_exp.size() < 4) rx_exp.push_back(d);
      else ovr_exp = 1'b1;
    end
    if (flip) par_exp = 1'b1;
    if (!stop) frm_exp = 1'b1;
    rx_head(d, flip);
    rx_bit(stop);
    rx = 1'b1;
  endtask

  task automatic pop_rx(input string tag);
    logic [31:0] e;
    if (rx_exp.size() != 0) e = 32'(rx_exp.pop_front());
    else e = 32'hFFFF_FFFF;
    @(negedge clk);
    chk(tag, recv_data, e);
    @(posedge clk); #1 recv_flag = 1'b1;
    @(posedge clk); #1 recv_flag = 1'b0;
  endtask

  task automatic clear_errs();
    @(posedge clk); #1 err_clear = 1'b1;
    par_exp = 1'b0; frm_exp = 1'b0; ovr_exp = 1'b0;
    @(posedge clk); #1 err_clear = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    logic       e, busy_last;
    logic [7:0] d;
    int         m, k, low;

    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_tx", tx, 1);
    chk("rst_sendable", sendable, 1);
    chk("rst_busy", tx_busy, 0);
    chk("rst_data", recv_data, 0);
    chk_errs("rst");

    // TX frame for 0xA5: start, 8 data bits LSB first, even parity, stop.
    d = 8'hA5;
    tx_exp.push_back(1'b0);
    for (int i = 0; i < 8; i++) tx_exp.push_back(d[i]);
    tx_exp.push_back(^d);
    tx_exp.push_back(1'b1);
    @(posedge clk); #1 send_flag = 1'b1; send_data = d;
    @(posedge clk); #1 send_flag = 1'b0;
    @(negedge clk);
    chk("busy_n", tx_busy, 0);
    chk("tx_n", tx, 1);
    @(negedge clk);
    chk("busy_n1", tx_busy, 1);
    chk("tx_n1", tx, 1);
    @(negedge clk);
    busy_last = 1'b0;
    for (int b = 0; b < 11; b++) begin
      e = tx_exp.pop_front();
      m = 0;
      for (int c = 0; c < C; c++) begin
        if (tx === e) m++;
        if (b == 10 && c == C - 1) busy_last = tx_busy;
        @(negedge clk);
      end
      chk($sformatf("tx_bit%0d", b), m, C);
    end
    chk("busy_in_stop", busy_last, 1);
    chk("busy_done", tx_busy, 0);
    chk("tx_idle", tx, 1);

    // RX 0x3C with exact receivable latency from the start of the stop bit.
    @(posedge clk); #1;
    rx_exp.push_back(8'h3C);
    rx_head(8'h3C, 1'b0);
    rx = 1'b1;
    repeat (10) @(posedge clk);
    @(negedge clk);
    chk("rx_lat_early", receivable, 0);
    @(posedge clk);
    @(negedge clk);
    chk("rx_lat", receivable, 1);
    repeat (5) @(posedge clk);
    #1;
    pop_rx("rx_3c");
    @(negedge clk);
    chk_errs("rx_3c");

    // Five frames into a four-entry FIFO.
    @(posedge clk); #1;
    rx_frame(8'h81, 1'b0, 1'b1);
    rx_frame(8'h42, 1'b0, 1'b1);
    rx_frame(8'h24, 1'b0, 1'b1);
    rx_frame(8'h18, 1'b0, 1'b1);
    rx_frame(8'hFF, 1'b0, 1'b1);
    repeat (4) @(posedge clk);
    @(negedge clk);
    chk_errs("ovr");
    for (int i = 0; i < 4; i++) pop_rx($sformatf("ovr_data%0d", i));
    @(negedge clk);
    chk("ovr_drained", receivable, rx_exp.size() != 0);
    clear_errs();
    chk_errs("ovr_clr");

    // Parity error, then framing error, then a short glitch.
    @(posedge clk); #1;
    rx_frame(8'h55, 1'b1, 1'b1);
    repeat (4) @(posedge clk);
    @(negedge clk);
    chk_errs("perr");
    @(posedge clk); #1;
    rx_frame(8'h66, 1'b0, 1'b0);
    repeat (4) @(posedge clk);
    @(negedge clk);
    chk_errs("ferr");
    clear_errs();
    chk_errs("err_clr");
    @(posedge clk); #1 rx = 1'b0;
    repeat (6) @(posedge clk);
    #1 rx = 1'b1;
    repeat (40) @(posedge clk);
    @(negedge clk);
    chk_errs("glitch");

    // Reset in the middle of the first of two queued frames.
    @(posedge clk); #1 send_flag = 1'b1; send_data = 8'h11;
    @(posedge clk); #1 send_data = 8'h22;
    @(posedge clk); #1 send_flag = 1'b0;
    k = 0;
    @(negedge clk);
    while (tx !== 1'b0 && k < 10) begin
      @(negedge clk);
      k++;
    end
    chk("rst_frame_start", tx, 0);
    repeat (40) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    chk("midrst_tx", tx, 1);
    chk("midrst_sendable", sendable, 1);
    chk("midrst_busy", tx_busy, 0);
    low = 0;
    repeat (400) begin
      @(negedge clk);
      if (tx !== 1'b1) low++;
    end
    chk("midrst_no_frames", low, 0);
    chk("midrst_busy_end", tx_busy, 0);

`ifdef UART_LOOPBACK_EN
    @(posedge clk); #1 loopback = 1'b1; rx = 1'b0;
    @(posedge clk); #1 send_flag = 1'b1; send_data = 8'h5A;
    rx_exp.push_back(8'h5A);
    @(posedge clk); #1 send_flag = 1'b0;
    low = 0;
    k = 0;
    while (!receivable && k < 400) begin
      @(negedge clk);
      if (tx !== 1'b1) low++;
      k++;
    end
    chk("lb_recv", receivable, 1);
    pop_rx("lb_data");
    repeat (30) begin
      @(negedge clk);
      if (tx !== 1'b1) low++;
    end
    chk("lb_tx_high", low, 0);
    @(posedge clk); #1 rx = 1'b1;
    repeat (4) @(posedge clk);
    #1 loopback = 1'b0;
    @(negedge clk);
    chk_errs("lb");
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
